// File: rtl/spi_target_sync.sv
// ---------------------------------------------------------------------------
// spi_target_sync
//   SPI mode-0 target that runs entirely on the system clock. The SPI pins are
//   oversampled through synchronizers and SCLK edges are detected in the clk
//   domain. Words are shifted MSB-first, and several words may be sent back to
//   back within one cs_n frame.
//
// Ports
//   clk, rst_n     system clock, synchronous active-low reset
//   sclk, cs_n,    SPI pins from the master, asynchronous to clk
//   mosi
//   miso           SPI data to the master (registered)
//   tx_data,       next word to send; tx_data is held while tx_valid is high
//   tx_valid
//   tx_ready       1-cycle pulse: a tx word was taken at a load point
//   rx_data        last complete received word
//   rx_valid       1-cycle pulse: rx_data was updated
//   busy           a frame is in progress
//   tx_underrun    1-cycle pulse: load point reached with no tx word available
//   frame_abort    1-cycle pulse: cs_n went high in the middle of a word
// ---------------------------------------------------------------------------
module spi_target_sync #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun,
    output logic                  frame_abort
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // -----------------------------------------------------------------------
    // Flop declarations
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_hist_q, sclk_hist_d;
    logic                   cs_hist_q,   cs_hist_d;

    state_e                 state_q, state_d;

    logic [CNT_W-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q,  tx_shift_d;
    // Only the lower DATA_WIDTH-1 bits are ever needed: the final bit comes
    // straight from mosi when the word completes.
    logic [DATA_WIDTH-2:0]  rx_shift_q,  rx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_data_q,   rx_data_d;

    logic                   miso_q,        miso_d;
    logic                   tx_ready_q,    tx_ready_d;
    logic                   rx_valid_q,    rx_valid_d;
    logic                   busy_q,        busy_d;
    logic                   tx_underrun_q, tx_underrun_d;
    logic                   frame_abort_q, frame_abort_d;

    // -----------------------------------------------------------------------
    // Synchronized pin levels and edge strobes
    // -----------------------------------------------------------------------
    logic                  sclk_s;
    logic                  cs_s;
    logic                  mosi_s;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  cs_fall;
    logic                  cs_rise;
    logic [DATA_WIDTH-1:0] rx_word;
    logic                  load;

    // Synchronizer shift chains and edge history
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_hist_d = sclk_s;
        cs_hist_d   = cs_s;
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign cs_fall   = ~cs_s & cs_hist_q;
    assign cs_rise   = cs_s & ~cs_hist_q;

    // Word as it would be with the current mosi bit appended
    assign rx_word = {rx_shift_q, mosi_s};

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs and datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        tx_ready_d    = 1'b0;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        frame_abort_d = 1'b0;
        load          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // SCLK edges outside a frame are ignored
                if (cs_fall) begin
                    load      = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            ST_ACTIVE: begin
                // cs_rise wins over an SCLK edge seen in the same cycle
                if (cs_rise) begin
                    if (bit_cnt_q != '0) begin
                        frame_abort_d = 1'b1;
                    end
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_word[DATA_WIDTH-2:0];
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    // The fall right after a completed word is the next load point
                    if (bit_cnt_q == '0) begin
                        load = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: begin
                bit_cnt_d = '0;
            end
        endcase

        // Load point: take a tx word if offered, otherwise send zeros
        if (load) begin
            if (tx_valid) begin
                tx_shift_d = tx_data;
                tx_ready_d = 1'b1;
            end else begin
                tx_shift_d    = '0;
                tx_underrun_d = 1'b1;
            end
        end

        busy_d = (state_d == ST_ACTIVE);
        miso_d = (state_d == ST_ACTIVE) ? tx_shift_d[DATA_WIDTH-1] : 1'b0;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q   <= '0;
            cs_sync_q     <= '1;
            mosi_sync_q   <= '0;
            sclk_hist_q   <= 1'b0;
            cs_hist_q     <= 1'b1;
            bit_cnt_q     <= '0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            miso_q        <= 1'b0;
            tx_ready_q    <= 1'b0;
            rx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sclk_hist_q   <= sclk_hist_d;
            cs_hist_q     <= cs_hist_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            miso_q        <= miso_d;
            tx_ready_q    <= tx_ready_d;
            rx_valid_q    <= rx_valid_d;
            busy_q        <= busy_d;
            tx_underrun_q <= tx_underrun_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign miso        = miso_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = busy_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_target_sync.sv
// ---------------------------------------------------------------------------
// tb_spi_target_sync
//   Drives spi_target_sync as a slow mode-0 SPI master plus a local tx source.
//   Expected rx words are queued when a frame is driven and matched against
//   the words the DUT reports; miso is checked at every sclk rise.
// ---------------------------------------------------------------------------
module tb_spi_target_sync;

    localparam int HP = 6;  // sclk half-period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       tx_underrun;
    logic       frame_abort;

    always #5 clk = ~clk;

    spi_target_sync #(
        .DATA_WIDTH (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .tx_underrun(tx_underrun),
        .frame_abort(frame_abort)
    );

    int n_total = 0;
    int n_bad   = 0;

    // tx source: words written by the stimulus, consumed on handshake
    logic [7:0] tx_words [16];
    int         tx_wr = 0;
    int         tx_rd = 0;

    // observed rx words and pulse counters, written only by the monitor
    logic [7:0] rx_obs [16];
    int         obs_wr = 0;
    int         obs_rd = 0;
    int         rdy_cnt = 0;
    int         und_cnt = 0;
    int         abt_cnt = 0;
    int         rdy_novalid = 0;

    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor and local tx driver, away from the active edge
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_obs[obs_wr % 16] = rx_data;
            obs_wr++;
        end
        if (tx_ready) begin
            rdy_cnt++;
            if (!tx_valid) rdy_novalid++;
        end
        if (tx_underrun) und_cnt++;
        if (frame_abort) abt_cnt++;
        if (tx_ready && tx_valid) tx_rd++;
        tx_valid = (tx_rd != tx_wr);
        tx_data  = tx_words[tx_rd % 16];
    end

    task automatic push_tx(input logic [7:0] w);
        tx_words[tx_wr % 16] = w;
        tx_wr++;
        @(negedge clk);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HP) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // nbits sclk periods; bit i of the word goes out MSB-first
    task automatic spi_bits(input logic [7:0] mo, input logic [7:0] exp_mi,
                            input bit chk_mi, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            repeat (HP) @(negedge clk);
            if (chk_mi) check("miso", 32'(miso), 32'(exp_mi[7-i]));
            check("busy_frame", 32'(busy), 32'd1);
            sclk = 1'b1;
            repeat (HP) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    // Match observed rx words against the scoreboard, bounded wait
    task automatic drain_rx();
        int b;
        b = 0;
        while ((obs_wr - obs_rd) < exp_q.size() && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("rx_count", 32'(obs_wr - obs_rd), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            check("rx_data", 32'(rx_obs[obs_rd % 16]), 32'(exp_q.pop_front()));
            obs_rd++;
        end
        exp_q.delete();
        obs_rd = obs_wr;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_miso"}, 32'(miso), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, u0, a0;
        rst_n = 1'b0;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_tx_ready", 32'(tx_ready), 32'h0);
        rst_n = 1'b1;

        // Idle with cs_n high
        repeat (20) @(negedge clk);
        check_idle("idle");
        check("idle_rdy_cnt", 32'(rdy_cnt), 32'd0);
        check("idle_und_cnt", 32'(und_cnt), 32'd0);
        check("idle_abt_cnt", 32'(abt_cnt), 32'd0);
        check("idle_rx_cnt", 32'(obs_wr), 32'd0);

        // Single word: send A5, receive 3C
        r0 = rdy_cnt; u0 = und_cnt; a0 = abt_cnt;
        push_tx(8'hA5);
        exp_q.push_back(8'h3C);
        cs_low();
        spi_bits(8'h3C, 8'hA5, 1'b1, 8);
        cs_high();
        drain_rx();
        check("single_rdy", 32'(rdy_cnt - r0), 32'd1);
        check("single_und", 32'(und_cnt - u0), 32'd1);
        check("single_abt", 32'(abt_cnt - a0), 32'd0);
        check_idle("single_end");

        // Two words in one frame
        r0 = rdy_cnt; u0 = und_cnt;
        push_tx(8'h81);
        push_tx(8'h7E);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h0F);
        cs_low();
        spi_bits(8'hF0, 8'h81, 1'b1, 8);
        spi_bits(8'h0F, 8'h7E, 1'b1, 8);
        cs_high();
        drain_rx();
        check("two_rdy", 32'(rdy_cnt - r0), 32'd2);
        check("two_und", 32'(und_cnt - u0), 32'd1);

        // Underrun: nothing offered at either load point
        r0 = rdy_cnt; u0 = und_cnt;
        exp_q.push_back(8'h55);
        cs_low();
        spi_bits(8'h55, 8'h00, 1'b1, 8);
        cs_high();
        drain_rx();
        check("under_rdy", 32'(rdy_cnt - r0), 32'd0);
        check("under_und", 32'(und_cnt - u0), 32'd2);

        // Abort after 5 bits
        r0 = rdy_cnt; u0 = und_cnt; a0 = abt_cnt;
        cs_low();
        spi_bits(8'hE7, 8'h00, 1'b1, 5);
        cs_high();
        drain_rx();
        check("abort_pulse", 32'(abt_cnt - a0), 32'd1);
        check("abort_rx_hold", 32'(rx_data), 32'h55);
        check("abort_und", 32'(und_cnt - u0), 32'd1);
        check_idle("abort_end");

        // Clean frame after the abort
        r0 = rdy_cnt; u0 = und_cnt; a0 = abt_cnt;
        push_tx(8'h5A);
        exp_q.push_back(8'hC3);
        cs_low();
        spi_bits(8'hC3, 8'h5A, 1'b1, 8);
        cs_high();
        drain_rx();
        check("post_abort_rdy", 32'(rdy_cnt - r0), 32'd1);
        check("post_abort_abt", 32'(abt_cnt - a0), 32'd0);

        // Reset in the middle of a frame
        cs_low();
        spi_bits(8'h3C, 8'h00, 1'b0, 4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_miso", 32'(miso), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_rx_data", 32'(rx_data), 32'h0);
        check("midrst_rx_valid", 32'(rx_valid), 32'h0);
        check("midrst_tx_ready", 32'(tx_ready), 32'h0);
        check("midrst_underrun", 32'(tx_underrun), 32'h0);
        check("midrst_abort", 32'(frame_abort), 32'h0);
        spi_bits(8'hC0, 8'h00, 1'b0, 4);
        cs_high();
        drain_rx();

        // Full frame after the reset
        r0 = rdy_cnt;
        push_tx(8'h66);
        exp_q.push_back(8'h99);
        cs_low();
        spi_bits(8'h99, 8'h66, 1'b1, 8);
        cs_high();
        drain_rx();
        check("post_rst_rdy", 32'(rdy_cnt - r0), 32'd1);
        check_idle("final");
        check("rdy_without_valid", 32'(rdy_novalid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
